// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared SHA-256 definitions for the compression core:
//   - FSM state encoding for the round engine
//   - initial hash value (IV) words H0_INIT..H7_INIT and the packed IV
//   - 64-entry round-constant table, read through k_of(t)
//   - bit-level helpers rotr, big_sigma0, big_sigma1, ch, maj
// -----------------------------------------------------------------------------
package sha256_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

  localparam logic [31:0] H0_INIT = 32'h6a09e667;
  localparam logic [31:0] H1_INIT = 32'hbb67ae85;
  localparam logic [31:0] H2_INIT = 32'h3c6ef372;
  localparam logic [31:0] H3_INIT = 32'ha54ff53a;
  localparam logic [31:0] H4_INIT = 32'h510e527f;
  localparam logic [31:0] H5_INIT = 32'h9b05688c;
  localparam logic [31:0] H6_INIT = 32'h1f83d9ab;
  localparam logic [31:0] H7_INIT = 32'h5be0cd19;

  // H0 occupies the most significant word, matching the digest layout.
  localparam logic [255:0] IV = {H0_INIT, H1_INIT, H2_INIT, H3_INIT,
                                 H4_INIT, H5_INIT, H6_INIT, H7_INIT};

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_of(input logic [5:0] t);
    return K_TAB[t];
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round_fn.sv
// -----------------------------------------------------------------------------
// sha256_round_fn
// Purely combinational single SHA-256 compression round.
// Ports:
//   i_work [255:0]  working variables {a,b,c,d,e,f,g,h}, a in [255:224]
//   i_k    [31:0]   round constant K[t]
//   i_w    [31:0]   schedule word W[t]
//   o_work [255:0]  working variables after the round, same packing
// -----------------------------------------------------------------------------
module sha256_round_fn
  import sha256_pkg::*;
(
  input  logic [255:0] i_work,
  input  logic [31:0]  i_k,
  input  logic [31:0]  i_w,
  output logic [255:0] o_work
);

  logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [31:0] w_t1, w_t2;

  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_work;

  // All sums wrap modulo 2^32 through the 32-bit result width.
  assign w_t1 = w_h + big_sigma1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
  assign w_t2 = big_sigma0(w_a) + maj(w_a, w_b, w_c);

  assign o_work = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

// File: rtl/sha256_round_engine.sv
// -----------------------------------------------------------------------------
// sha256_round_engine
// Iterative SHA-256 compression core: one 512-bit block in ROUNDS single-cycle
// rounds, fed one schedule word per round over a valid/ready handshake.
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   start            begin a block (honoured only in IDLE)
//   first_block      with start: 1 = seed H from IV, 0 = chain from current H
//   w_valid, w_data  schedule word W[t] for the current round
//   w_ready          engine consumes W[t] this cycle (ROUND state)
//   busy             high in every state except IDLE
//   done             one-cycle pulse once the digest holds the block result
//   round_idx        current round t, 0 outside ROUND
//   digest           {H0..H7}, H0 in [255:224]
// -----------------------------------------------------------------------------
module sha256_round_engine
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         first_block,
  input  logic         w_valid,
  input  logic [31:0]  w_data,
  output logic         w_ready,
  output logic         busy,
  output logic         done,
  output logic [5:0]   round_idx,
  output logic [255:0] digest
);

  state_t       r_state, w_state_nxt;
  logic [255:0] r_h, r_work;
  logic [5:0]   r_t;
  logic [255:0] w_work_nxt, w_h_sum;
  logic [31:0]  w_k;
  logic         w_fire, w_last;

  assign w_k    = k_of(r_t);
  assign w_fire = (r_state == ROUND) && w_valid;
  assign w_last = (r_t == 6'(ROUNDS - 1));

  sha256_round_fn u_round (
    .i_work (r_work),
    .i_k    (w_k),
    .i_w    (w_data),
    .o_work (w_work_nxt)
  );

  // Final feed-forward: each chaining word plus its working variable.
  always_comb begin
    w_h_sum = '0;
    for (int i = 0; i < 8; i++) begin
      w_h_sum[i*32 +: 32] = r_h[i*32 +: 32] + r_work[i*32 +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    round_idx   = '0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = LOAD;
      end
      LOAD:  w_state_nxt = ROUND;
      ROUND: begin
        w_ready   = 1'b1;
        round_idx = r_t;
        if (w_fire && w_last) w_state_nxt = FINAL;
      end
      FINAL: w_state_nxt = DONE;
      DONE: begin
        // A start here is deliberately dropped; it must be re-issued in IDLE.
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h    <= IV;
      r_work <= '0;
      r_t    <= '0;
    end else begin
      case (r_state)
        IDLE:  if (start && first_block) r_h <= IV;
        LOAD: begin
          r_work <= r_h;
          r_t    <= '0;
        end
        ROUND: begin
          if (w_fire) begin
            r_work <= w_work_nxt;
            r_t    <= r_t + 6'd1;
          end
        end
        FINAL: r_h <= w_h_sum;
        default: ;
      endcase
    end
  end

  assign digest = r_h;

endmodule
